// File: rtl/screen_ctrl.sv
// screen_ctrl: start-key debounce, START/PLAY/OVER game FSM with frame-aligned commits, and renderer pixel mux
module screen_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int OVER_FRAMES     = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  xcnt,
    input  logic [9:0]  ycnt,
    input  logic        de,
    input  logic        key_n,
    input  logic        game_over,
    input  logic [15:0] start_rgb,
    input  logic [15:0] game_rgb,
    input  logic [15:0] over_rgb,
    output logic [15:0] rgb565,
    output logic [1:0]  state,
    output logic        game_rst,
    output logic        game_run
);
    typedef enum logic [1:0] {S_START = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2, S_BAD = 2'd3} state_t;
    localparam logic [17:0] DB_LAST = 18'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  OF_MAX  = 8'(OVER_FRAMES);
    state_t      cur, pend_state, state_nx, evt_state;
    logic        key_s1, key_s2, stable, press;
    logic [17:0] db_cnt;
    logic        frame_start, pend_valid, evt_valid, commit, de_d;
    logic [7:0]  frame_cnt;
    logic [15:0] sel;
    assign state = cur;
    // key synchronizer and debounce: count while the synced level disagrees with the stable level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            stable <= 1'b1;
            db_cnt <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            if (key_s2 == stable) db_cnt <= '0;
            else if (db_cnt == DB_LAST) begin
                stable <= key_s2;
                db_cnt <= '0;
            end else db_cnt <= db_cnt + 18'd1;
        end
    end
    // request detection, commit decision and pixel source selection
    always_comb begin
        press       = (key_s2 != stable) && (db_cnt == DB_LAST) && !key_s2;
        frame_start = de && (xcnt == 10'd0) && (ycnt == 10'd0);
        commit      = frame_start && pend_valid;
        evt_valid   = 1'b0;
        evt_state   = S_START;
        if (cur == S_START && press) begin
            evt_valid = 1'b1;
            evt_state = S_PLAY;
        end else if (cur == S_PLAY && game_over) begin
            evt_valid = 1'b1;
            evt_state = S_OVER;
        end else if (cur == S_OVER && (press || frame_cnt == OF_MAX)) begin
            evt_valid = 1'b1;
            evt_state = S_START;
        end
        state_nx = (cur == S_BAD) ? S_START : commit ? pend_state : cur;
        sel      = (cur == S_PLAY) ? game_rgb : (cur == S_OVER) ? over_rgb : start_rgb;
    end
    // state register, pending request, PLAY-entry pulse and OVER frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur        <= S_START;
            pend_valid <= 1'b0;
            pend_state <= S_START;
            game_rst   <= 1'b0;
            game_run   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            cur      <= state_nx;
            game_run <= (state_nx == S_PLAY);
            game_rst <= commit && (pend_state == S_PLAY) && (cur != S_BAD);
            if (commit) pend_valid <= 1'b0;
            else if (evt_valid && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_state <= evt_state;
            end
            if (commit) frame_cnt <= '0;
            else if (frame_start && cur == S_OVER && frame_cnt != OF_MAX) frame_cnt <= frame_cnt + 8'd1;
        end
    end
    // two-stage pixel pipe: align de with renderer latency, then blank or pass the selected pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_d   <= 1'b0;
            rgb565 <= '0;
        end else begin
            de_d   <= de;
            rgb565 <= de_d ? sel : 16'h0000;
        end
    end
endmodule

// File: tb/tb_screen_ctrl.sv
// tb_screen_ctrl: randomized stimulus against a behavioural game/pixel model of screen_ctrl
module tb_screen_ctrl;
    localparam int DB = 8;
    localparam int OF = 3;
    localparam int H_TOT = 20;
    localparam int V_TOT = 10;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  xcnt, ycnt;
    logic        de, key_n, game_over;
    logic [15:0] start_rgb, game_rgb, over_rgb, rgb565;
    logic [1:0]  state;
    logic        game_rst, game_run;
    int          n_chk = 0, n_fail = 0;
    int          hc = 0, vc = 0;
    logic        key = 1'b1, go = 1'b0;
    logic        m_s1 = 1'b1, m_s2 = 1'b1, m_stable = 1'b1, m_de_d = 1'b0, m_rst = 1'b0;
    int          m_run = 0, m_state = 0, m_pend = -1, m_fcnt = 0;
    logic [15:0] m_rgb = '0;
    screen_ctrl #(.DEBOUNCE_CYCLES(DB), .OVER_FRAMES(OF)) dut (
        .clk(clk), .rst_n(rst_n), .xcnt(xcnt), .ycnt(ycnt), .de(de), .key_n(key_n),
        .game_over(game_over), .start_rgb(start_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
        .rgb565(rgb565), .state(state), .game_rst(game_rst), .game_run(game_run)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask
    // one clock of the game as the rules describe it, evaluated on the inputs presented this cycle
    task automatic model_step();
        logic fs, press, commit;
        int   evt, old;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_run = 0;
            m_state = 0; m_pend = -1; m_fcnt = 0; m_de_d = 1'b0; m_rgb = '0; m_rst = 1'b0;
            return;
        end
        fs = de && xcnt == 0 && ycnt == 0;
        press = 1'b0;
        if (m_s2 != m_stable) begin
            m_run++;
            if (m_run == DB) begin
                m_stable = m_s2;
                press = !m_s2;
                m_run = 0;
            end
        end else m_run = 0;
        m_s2 = m_s1;
        m_s1 = key_n;
        evt = -1;
        if (m_state == 0 && press) evt = 1;
        else if (m_state == 1 && game_over) evt = 2;
        else if (m_state == 2 && (press || m_fcnt >= OF)) evt = 0;
        commit = fs && m_pend >= 0;
        m_rst = commit && m_pend == 1;
        old = m_state;
        m_rgb = !m_de_d ? 16'h0 : old == 1 ? game_rgb : old == 2 ? over_rgb : start_rgb;
        m_de_d = de;
        if (commit) begin
            m_state = m_pend;
            m_pend = -1;
            m_fcnt = 0;
        end else begin
            if (evt >= 0 && m_pend < 0) m_pend = evt;
            if (fs && old == 2 && m_fcnt < OF) m_fcnt++;
        end
    endtask
    // compare last edge's outputs, present the next inputs, advance the model and the raster
    task automatic cyc();
        check("state", 32'(state), 32'(m_state));
        check("game_run", 32'(game_run), 32'(m_state == 1));
        check("game_rst", 32'(game_rst), 32'(m_rst));
        check("rgb565", 32'(rgb565), 32'(m_rgb));
        xcnt = 10'(hc);
        ycnt = 10'(vc);
        de = hc < 16 && vc < 8;
        key_n = key;
        game_over = go;
        start_rgb = 16'($urandom);
        game_rgb = 16'($urandom);
        over_rgb = 16'($urandom);
        model_step();
        hc = (hc == H_TOT - 1) ? 0 : hc + 1;
        if (hc == 0) vc = (vc == V_TOT - 1) ? 0 : vc + 1;
        @(negedge clk);
    endtask
    task automatic run_until(input int x, input int y);
        for (int i = 0; i < 2 * H_TOT * V_TOT && !(hc == x && vc == y); i++) cyc();
    endtask
    task automatic next_at(input int x, input int y);
        cyc();
        run_until(x, y);
    endtask
    task automatic press_key();
        key = 1'b0;
        repeat (20) cyc();
        key = 1'b1;
        repeat (20) cyc();
    endtask
    initial begin
        rst_n = 1'b0;
        xcnt = '0; ycnt = '0; de = 1'b0; key_n = 1'b1; game_over = 1'b0;
        start_rgb = '0; game_rgb = '0; over_rgb = '0;
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        repeat (5 * H_TOT * V_TOT) cyc();
        check("idle_start", 32'(state), 32'd0);
        key = 1'b0;
        repeat (4) cyc();
        key = 1'b1;
        next_at(8, 2);
        next_at(8, 2);
        check("bounce_ignored", 32'(state), 32'd0);
        press_key();
        next_at(8, 2);
        check("play_entered", 32'(state), 32'd1);
        check("play_run", 32'(game_run), 32'd1);
        run_until(5, 3);
        go = 1'b1;
        cyc();
        go = 1'b0;
        run_until(10, 7);
        check("over_waits_frame", 32'(state), 32'd1);
        next_at(8, 2);
        check("over_entered", 32'(state), 32'd2);
        for (int f = 0; f < OF; f++) begin
            next_at(8, 2);
            check("over_held", 32'(state), 32'd2);
        end
        next_at(8, 2);
        check("over_auto_return", 32'(state), 32'd0);
        run_until(11, 9);
        key = 1'b0;
        repeat (20) cyc();
        key = 1'b1;
        run_until(8, 4);
        check("coincide_delayed", 32'(state), 32'd0);
        next_at(8, 4);
        check("coincide_commit", 32'(state), 32'd1);
        run_until(5, 3);
        go = 1'b1;
        cyc();
        go = 1'b0;
        next_at(8, 2);
        check("over_again", 32'(state), 32'd2);
        press_key();
        next_at(8, 2);
        check("over_key_return", 32'(state), 32'd0);
        press_key();
        next_at(8, 2);
        check("play_before_rst", 32'(state), 32'd1);
        run_until(7, 4);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_rgb", 32'(rgb565), 32'd0);
        check("rst_run", 32'(game_run), 32'd0);
        for (int i = 0; i < 30 * H_TOT * V_TOT; i++) begin
            if ($urandom_range(0, 49) == 0) key = ~key;
            go = ($urandom_range(0, 199) == 0);
            cyc();
        end
        go = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
